// File: rtl/wb_src_select.sv
// Writeback source select: picks one of NSRC sources and registers it as the writeback value.
// Latency: 1 cycle when the selected source is valid, otherwise 1 cycle after it becomes valid (or times out).
// Backpressure: stalls in WAIT while the source is invalid; req is ignored until out_valid completes the operation.
module wb_src_select #(
  parameter int WIDTH   = 32,
  parameter int NSRC    = 6,
  parameter int SEL_W   = 3,
  parameter int TIMEOUT = 63
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  req,
  input  logic [SEL_W-1:0]      sel,
  input  logic [NSRC*WIDTH-1:0] src_data,
  input  logic [NSRC-1:0]       src_valid,
  output logic [WIDTH-1:0]      out,
  output logic                  out_valid,
  output logic                  busy,
  output logic                  err_sel,
  output logic                  err_timeout
);

  // Counter only needs to reach TIMEOUT-1; keep at least one bit so TIMEOUT=0 still elaborates.
  localparam int CNT_W = (TIMEOUT < 1) ? 1 : $clog2(TIMEOUT + 1);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'((TIMEOUT > 0) ? TIMEOUT - 1 : 0);

  typedef enum logic {
    S_IDLE,
    S_WAIT
  } state_t;

  state_t           state;
  logic [SEL_W-1:0] sel_q;
  logic [CNT_W-1:0] cnt;

  logic [SEL_W-1:0] idx;
  logic [WIDTH-1:0] hit_dat;
  logic             hit_vld;
  logic             sel_ok;

  // Look up the live index: the incoming sel in IDLE, the latched sel_q while waiting.
  always_comb begin
    idx     = (state == S_IDLE) ? sel : sel_q;
    hit_dat = '0;
    hit_vld = 1'b0;
    sel_ok  = 1'b0;
    for (int i = 0; i < NSRC; i++) begin
      if (idx == SEL_W'(i)) begin
        hit_dat = src_data[i*WIDTH +: WIDTH];
        hit_vld = src_valid[i];
        sel_ok  = 1'b1;
      end
    end
  end

  // Control FSM with registered outputs; pulses default low every cycle.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state       <= S_IDLE;
      out         <= '0;
      out_valid   <= 1'b0;
      busy        <= 1'b0;
      err_sel     <= 1'b0;
      err_timeout <= 1'b0;
      sel_q       <= '0;
      cnt         <= '0;
    end else begin
      out_valid   <= 1'b0;
      err_sel     <= 1'b0;
      err_timeout <= 1'b0;
      case (state)
        S_IDLE: begin
          if (req) begin
            if (!sel_ok) begin
              out       <= '0;
              out_valid <= 1'b1;
              err_sel   <= 1'b1;
            end else if (hit_vld) begin
              out       <= hit_dat;
              out_valid <= 1'b1;
            end else begin
              sel_q <= sel;
              cnt   <= '0;
              busy  <= 1'b1;
              state <= S_WAIT;
            end
          end
        end
        S_WAIT: begin
          // A source turning valid on the last allowed cycle still delivers data.
          if (hit_vld) begin
            out       <= hit_dat;
            out_valid <= 1'b1;
            busy      <= 1'b0;
            state     <= S_IDLE;
          end else if (TIMEOUT != 0 && cnt == CNT_LAST) begin
            out         <= '0;
            out_valid   <= 1'b1;
            err_timeout <= 1'b1;
            busy        <= 1'b0;
            state       <= S_IDLE;
          end else if (TIMEOUT != 0) begin
            cnt <= cnt + 1'b1;
          end
        end
        default: state <= S_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_wb_src_select.sv
// Self-checking bench for wb_src_select: default instance (TIMEOUT=63) plus a TIMEOUT=4 instance.
// Inputs change 1 time unit after the rising edge; outputs are sampled at the same point.
// Directed vectors with hand-computed expectations.
module tb_wb_src_select;

  localparam int W = 32;
  localparam int N = 6;
  localparam int S = 3;

  logic           clk = 1'b0;
  logic           reset;
  logic           req, req_to;
  logic [S-1:0]   sel;
  logic [N*W-1:0] src_data;
  logic [N-1:0]   src_valid;

  logic [W-1:0] out, out_to;
  logic out_valid, busy, err_sel, err_timeout;
  logic out_valid_to, busy_to, err_sel_to, err_timeout_to;

  int checks = 0;
  int fails  = 0;

  always #5 clk = ~clk;

  wb_src_select #(.WIDTH(W), .NSRC(N), .SEL_W(S), .TIMEOUT(63)) dut (
    .clk(clk), .reset(reset), .req(req), .sel(sel), .src_data(src_data), .src_valid(src_valid),
    .out(out), .out_valid(out_valid), .busy(busy), .err_sel(err_sel), .err_timeout(err_timeout)
  );

  wb_src_select #(.WIDTH(W), .NSRC(N), .SEL_W(S), .TIMEOUT(4)) dut_to (
    .clk(clk), .reset(reset), .req(req_to), .sel(sel), .src_data(src_data), .src_valid(src_valid),
    .out(out_to), .out_valid(out_valid_to), .busy(busy_to), .err_sel(err_sel_to), .err_timeout(err_timeout_to)
  );

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic set_src(input int i, input logic [W-1:0] v);
    src_data[i*W +: W] = v;
  endtask

  task automatic test_reset();
    reset = 1'b1; req = 0; req_to = 0; sel = '0; src_valid = '0; src_data = '0;
    tick(); tick();
    checks++; if (out !== 32'h0)       begin fails++; $display("FAIL reset_out got=%h exp=0", out); end
    checks++; if (out_valid !== 1'b0)  begin fails++; $display("FAIL reset_out_valid got=%b exp=0", out_valid); end
    checks++; if (busy !== 1'b0)       begin fails++; $display("FAIL reset_busy got=%b exp=0", busy); end
    checks++; if ({err_sel, err_timeout} !== 2'b00) begin fails++; $display("FAIL reset_err got=%b exp=00", {err_sel, err_timeout}); end
    reset = 1'b0;
    tick();
  endtask

  task automatic test_immediate();
    src_valid = 6'h3F;
    for (int i = 0; i < N; i++) set_src(i, 32'h1000_0000 + i);
    set_src(3, 32'h0000_00A5);
    req = 1; sel = 3;
    tick();
    req = 0;
    checks++; if (out !== 32'h0000_00A5) begin fails++; $display("FAIL imm_out got=%h exp=000000a5", out); end
    checks++; if (out_valid !== 1'b1)    begin fails++; $display("FAIL imm_out_valid got=%b exp=1", out_valid); end
    checks++; if (busy !== 1'b0)         begin fails++; $display("FAIL imm_busy got=%b exp=0", busy); end
    checks++; if (err_sel !== 1'b0)      begin fails++; $display("FAIL imm_err_sel got=%b exp=0", err_sel); end
    tick();
    checks++; if (out_valid !== 1'b0)    begin fails++; $display("FAIL imm_pulse got=%b exp=0", out_valid); end
    checks++; if (out !== 32'h0000_00A5) begin fails++; $display("FAIL imm_hold got=%h exp=000000a5", out); end
  endtask

  task automatic test_stall_hi();
    src_valid = 6'h3D;
    set_src(1, 32'hDEAD_BEEF);
    req = 1; sel = 1;
    tick();
    // Keep req high with a valid source while waiting: it must be ignored.
    sel = 3;
    checks++; if (busy !== 1'b1)         begin fails++; $display("FAIL stall_busy_w1 got=%b exp=1", busy); end
    checks++; if (out !== 32'h0000_00A5) begin fails++; $display("FAIL stall_out_w1 got=%h exp=000000a5", out); end
    for (int c = 2; c <= 4; c++) begin
      tick();
      checks++; if (busy !== 1'b1 || out_valid !== 1'b0) begin fails++; $display("FAIL stall_wait_c%0d busy=%b out_valid=%b exp busy=1 out_valid=0", c, busy, out_valid); end
      checks++; if (out !== 32'h0000_00A5) begin fails++; $display("FAIL stall_out_c%0d got=%h exp=000000a5", c, out); end
    end
    req = 0;
    src_valid = 6'h3F;
    tick();
    checks++; if (out !== 32'hDEAD_BEEF) begin fails++; $display("FAIL stall_out got=%h exp=deadbeef", out); end
    checks++; if (out_valid !== 1'b1 || busy !== 1'b0) begin fails++; $display("FAIL stall_done out_valid=%b busy=%b exp 1 0", out_valid, busy); end
    set_src(1, 32'h0);
    tick();
    checks++; if (out_valid !== 1'b0)    begin fails++; $display("FAIL stall_no_extra got=%b exp=0", out_valid); end
    checks++; if (out !== 32'hDEAD_BEEF) begin fails++; $display("FAIL stall_capture got=%h exp=deadbeef", out); end
  endtask

  task automatic test_invalid_sel();
    req = 1; sel = 6;
    tick();
    sel = 7;
    checks++; if (out !== 32'h0 || out_valid !== 1'b1 || err_sel !== 1'b1) begin fails++; $display("FAIL bad_sel6 out=%h ov=%b es=%b exp 0 1 1", out, out_valid, err_sel); end
    checks++; if (busy !== 1'b0) begin fails++; $display("FAIL bad_sel6_busy got=%b exp=0", busy); end
    tick();
    req = 0;
    checks++; if (out !== 32'h0 || out_valid !== 1'b1 || err_sel !== 1'b1) begin fails++; $display("FAIL bad_sel7 out=%h ov=%b es=%b exp 0 1 1", out, out_valid, err_sel); end
    tick();
    checks++; if (out_valid !== 1'b0 || err_sel !== 1'b0) begin fails++; $display("FAIL bad_sel_pulse ov=%b es=%b exp 0 0", out_valid, err_sel); end
  endtask

  task automatic test_timeout();
    // Load a nonzero value first so the zeroed timeout result is visible.
    set_src(0, 32'h0000_1234);
    src_valid = 6'h3F;
    req_to = 1; sel = 0;
    tick();
    checks++; if (out_to !== 32'h0000_1234) begin fails++; $display("FAIL to_preload got=%h exp=00001234", out_to); end
    src_valid = 6'h3E;
    tick();
    req_to = 0;
    checks++; if (busy_to !== 1'b1) begin fails++; $display("FAIL to_busy got=%b exp=1", busy_to); end
    for (int c = 2; c <= 4; c++) begin
      tick();
      checks++; if (busy_to !== 1'b1 || out_valid_to !== 1'b0) begin fails++; $display("FAIL to_wait_c%0d busy=%b ov=%b exp 1 0", c, busy_to, out_valid_to); end
    end
    tick();
    checks++; if (out_to !== 32'h0 || out_valid_to !== 1'b1 || err_timeout_to !== 1'b1) begin fails++; $display("FAIL to_expire out=%h ov=%b et=%b exp 0 1 1", out_to, out_valid_to, err_timeout_to); end
    checks++; if (busy_to !== 1'b0 || err_sel_to !== 1'b0) begin fails++; $display("FAIL to_expire_flags busy=%b es=%b exp 0 0", busy_to, err_sel_to); end
    checks++; if (out_valid !== 1'b0) begin fails++; $display("FAIL to_other_idle got=%b exp=0", out_valid); end
    tick();
    checks++; if (out_valid_to !== 1'b0 || err_timeout_to !== 1'b0) begin fails++; $display("FAIL to_pulse ov=%b et=%b exp 0 0", out_valid_to, err_timeout_to); end
    // Valid arrives in the 4th WAIT cycle: data wins over timeout.
    set_src(0, 32'h0BAD_F00D);
    req_to = 1;
    tick();
    req_to = 0;
    for (int c = 2; c <= 4; c++) tick();
    src_valid = 6'h3F;
    tick();
    checks++; if (out_to !== 32'h0BAD_F00D || out_valid_to !== 1'b1) begin fails++; $display("FAIL to_late_valid out=%h ov=%b exp 0badf00d 1", out_to, out_valid_to); end
    checks++; if (err_timeout_to !== 1'b0) begin fails++; $display("FAIL to_late_err got=%b exp=0", err_timeout_to); end
    tick();
  endtask

  task automatic test_reset_mid();
    src_valid = 6'h3D;
    req = 1; sel = 1;
    tick();
    req = 0;
    checks++; if (busy !== 1'b1) begin fails++; $display("FAIL rst_mid_busy got=%b exp=1", busy); end
    #2 reset = 1'b1;
    #1;
    checks++; if (busy !== 1'b0 || out !== 32'h0 || out_valid !== 1'b0) begin fails++; $display("FAIL rst_mid_async busy=%b out=%h ov=%b exp 0 0 0", busy, out, out_valid); end
    src_valid = 6'h3F;
    tick();
    reset = 1'b0;
    tick();
    checks++; if (out_valid !== 1'b0 || busy !== 1'b0) begin fails++; $display("FAIL rst_mid_abort ov=%b busy=%b exp 0 0", out_valid, busy); end
    req = 1; sel = 3;
    tick();
    req = 0;
    checks++; if (out !== 32'h0000_00A5 || out_valid !== 1'b1) begin fails++; $display("FAIL rst_mid_next out=%h ov=%b exp 000000a5 1", out, out_valid); end
    tick();
  endtask

  task automatic test_back_to_back();
    logic [W-1:0] exp_out;
    set_src(4, 32'h1111_0004);
    set_src(5, 32'h2222_0005);
    src_valid = 6'h3F;
    req = 1;
    for (int k = 0; k < 6; k++) begin
      sel = (k % 2 == 0) ? 3'd4 : 3'd5;
      exp_out = (k % 2 == 0) ? 32'h1111_0004 : 32'h2222_0005;
      tick();
      checks++; if (out_valid !== 1'b1 || out !== exp_out) begin fails++; $display("FAIL b2b_%0d out=%h ov=%b exp %h 1", k, out, out_valid, exp_out); end
    end
    req = 0;
    tick();
    checks++; if (out_valid !== 1'b0) begin fails++; $display("FAIL b2b_end got=%b exp=0", out_valid); end
  endtask

  initial begin
    test_reset();
    test_immediate();
    test_stall_hi();
    test_invalid_sel();
    test_timeout();
    test_reset_mid();
    test_back_to_back();
    $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
    $finish;
  end

endmodule
